// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch sequencer. Holds the pipeline until the
// branch operands are forwarded, resolves the branch from the comparator
// flags, and delivers a taken-branch redirect to fetch with a
// hold-until-accepted handshake. Not-taken branch-likely instructions annul
// their delay slot. Also keeps a saturating count of taken branches.
module branch_ctrl #(
  parameter int PCW  = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            BrValid,
  input  logic [2:0]      BrOp,
  input  logic            BrLikely,
  input  logic [PCW-1:0]  BrPC,
  input  logic [15:0]     BrImm,
  input  logic            RS_Rdy,
  input  logic            RT_Rdy,
  input  logic            CMPOut1,
  input  logic [1:0]      CMPOut2,
  input  logic            IF_Ready,
  output logic            Stall,
  output logic            Redirect,
  output logic [PCW-1:0]  Target,
  output logic            Annul,
  output logic [CNTW-1:0] TakenCnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIR} state_t;

  state_t          r_state;
  logic            r_redirect;
  logic [PCW-1:0]  r_target;
  logic            r_annul;
  logic [CNTW-1:0] r_cnt;

  logic            w_op_valid;
  logic            w_need_rt;
  logic            w_taken;
  logic            w_ready;
  logic [PCW-1:0]  w_off;
  logic [PCW-1:0]  w_target;

  // Decode the branch op: which operands it needs and whether it is taken.
  always_comb begin
    w_op_valid = 1'b1;
    w_need_rt  = 1'b0;
    w_taken    = 1'b0;
    case (BrOp)
      3'b001: begin w_need_rt = 1'b1; w_taken = ~CMPOut1;          end // BEQ
      3'b010: begin w_need_rt = 1'b1; w_taken = CMPOut1;           end // BNE
      3'b011: w_taken = (CMPOut2 != 2'b01);                            // BLEZ
      3'b100: w_taken = (CMPOut2 == 2'b01);                            // BGTZ
      3'b101: w_taken = (CMPOut2 == 2'b10);                            // BLTZ
      3'b110: w_taken = (CMPOut2 != 2'b10);                            // BGEZ
      default: w_op_valid = 1'b0;                                      // none / reserved
    endcase
  end

  assign w_ready  = RS_Rdy & (~w_need_rt | RT_Rdy);
  // Word offset, sign-extended to the PC width; wraps modulo 2^PCW.
  assign w_off    = {{(PCW-16){BrImm[15]}}, BrImm} << 2;
  assign w_target = BrPC + PCW'(4) + w_off;

  // Stall is combinational so an unready branch freezes IF/ID in the same
  // cycle; during a redirect any new branch waits until we are back in IDLE.
  always_comb begin
    Stall = 1'b0;
    case (r_state)
      S_IDLE:  Stall = BrValid & w_op_valid & ~w_ready;
      S_WAIT:  Stall = BrValid & w_op_valid & ~w_ready;
      S_REDIR: Stall = BrValid;
      default: Stall = 1'b0;
    endcase
  end

  // Sequencing FSM with registered Redirect/Target/Annul and the taken counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_redirect <= 1'b0;
      r_target   <= '0;
      r_annul    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_annul <= 1'b0;
      case (r_state)
        S_IDLE, S_WAIT: begin
          // BrValid low in WAIT means ID was flushed: abandon, even if the
          // operands happen to become ready in that same cycle.
          if (BrValid && w_op_valid) begin
            if (w_ready) begin
              if (w_taken) begin
                r_target   <= w_target;
                r_redirect <= 1'b1;
                r_state    <= S_REDIR;
                if (r_cnt != {CNTW{1'b1}}) r_cnt <= r_cnt + CNTW'(1);
              end else begin
                r_annul <= BrLikely;
                r_state <= S_IDLE;
              end
            end else begin
              r_state <= S_WAIT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REDIR: begin
          if (IF_Ready) begin
            r_redirect <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Redirect = r_redirect;
  assign Target   = r_target;
  assign Annul    = r_annul;
  assign TakenCnt = r_cnt;

endmodule
